// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment decode path.
//   SEG7_PATTERNS : segment patterns (bits g..a) for hex digits 0..F, indexed by value
//   BLANK         : all-segments-off pattern
//   state_t       : lock state of the decoder
package seg7_pkg;

    localparam logic [6:0] SEG7_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} state_t;

endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: combinational reverse lookup of a 7-segment pattern to its hex value.
//   pattern : segment bits g..a (dp excluded)
//   hit     : pattern matches one of the 16 hex glyphs
//   value   : decoded hex value, 0 when no hit
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b0;
        value = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_PATTERNS[i]) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: debounced monitor that recovers the hex digit shown on a segment bus.
//   clk_2        : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   seg_in       : observed segment bus {dp, g..a}
//   digit_out    : last accepted valid digit
//   dp_out       : dp of the last accepted pattern
//   blank        : last accepted pattern had no segments lit
//   digit_valid  : one-cycle pulse on acceptance of a decodable pattern
//   seg_error    : one-cycle pulse on acceptance of a lit but undecodable pattern
//   err_sticky   : latched seg_error, cleared by reset only
//   change_count : saturating count of acceptances
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int NBITS_SEG     = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic [3:0]           digit_out,
    output logic                 dp_out,
    output logic                 blank,
    output logic                 digit_valid,
    output logic                 seg_error,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     change_count
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t               state_q, state_d;
    logic [NBITS_SEG-1:0] samp_q, locked_q;
    logic [7:0]           stab_q, stab_d;
    logic                 have_lock_q;
    logic [3:0]           digit_q;
    logic                 dp_q, blank_q, valid_q, error_q, sticky_q;
    logic [CNT_W-1:0]     count_q;
    logic                 hit, accept, is_blank;
    logic [3:0]           value;

    seg7_lut u_lut (
        .pattern (seg_in[6:0]),
        .hit     (hit),
        .value   (value)
    );

    // A change against the previous sample restarts the run; the run length
    // saturates so a held pattern keeps reporting "stable".
    always_comb begin
        stab_d   = (seg_in != samp_q) ? 8'd1 : (stab_q >= STABLE) ? STABLE : stab_q + 8'd1;
        accept   = (stab_d == STABLE) && (!have_lock_q || seg_in != locked_q);
        is_blank = seg_in[6:0] == BLANK;
        state_d  = accept ? LOCKED
                 : (state_q != IDLE && have_lock_q && seg_in == locked_q) ? LOCKED
                 : SETTLING;
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            stab_q      <= '0;
            locked_q    <= '0;
            have_lock_q <= 1'b0;
            digit_q     <= '0;
            dp_q        <= 1'b0;
            blank_q     <= 1'b1;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            samp_q  <= seg_in;
            stab_q  <= stab_d;
            valid_q <= accept && hit;
            error_q <= accept && !hit && !is_blank;
            if (accept) begin
                locked_q    <= seg_in;
                have_lock_q <= 1'b1;
                dp_q        <= seg_in[NBITS_SEG-1];
                blank_q     <= is_blank;
                count_q     <= &count_q ? count_q : count_q + CNT_W'(1);
                if (hit) digit_q <= value;
                if (!hit && !is_blank) sticky_q <= 1'b1;
            end
        end
    end

    assign digit_out    = digit_q;
    assign dp_out       = dp_q;
    assign blank        = blank_q;
    assign digit_valid  = valid_q;
    assign seg_error    = error_q;
    assign err_sticky   = sticky_q;
    assign change_count = count_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: scoreboard bench for seg7_decoder against a history-based reference model.
module tb_seg7_decoder;

    localparam int SC = 4;

    typedef struct {
        logic [3:0] digit;
        logic       dp, bl, vld, err, sticky;
        logic [7:0] cnt;
    } exp_t;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [3:0] digit_out;
    logic       dp_out, blank, digit_valid, seg_error, err_sticky;
    logic [7:0] change_count;

    int n_chk = 0;
    int n_fail = 0;

    exp_t exp_q[$];

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [7:0] hist[$];
    logic [7:0] m_locked;
    bit         m_have;
    exp_t       m;

    seg7_decoder #(.NBITS_SEG(8), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk_2        (clk_2),
        .reset_n      (reset_n),
        .seg_in       (seg_in),
        .digit_out    (digit_out),
        .dp_out       (dp_out),
        .blank        (blank),
        .digit_valid  (digit_valid),
        .seg_error    (seg_error),
        .err_sticky   (err_sticky),
        .change_count (change_count)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_have   = 0;
        m_locked = 8'h00;
        m = '{digit: 4'd0, dp: 1'b0, bl: 1'b1, vld: 1'b0, err: 1'b0, sticky: 1'b0, cnt: 8'd0};
    endtask

    // A pattern is accepted once the last SC sampled values are identical
    // and differ from whatever is currently locked.
    task automatic model_edge(input logic [7:0] p);
        bit stable, found;
        int v;
        hist.push_back(p);
        if (hist.size() > SC) void'(hist.pop_front());
        stable = hist.size() == SC;
        foreach (hist[i]) if (hist[i] != p) stable = 0;
        m.vld = 0;
        m.err = 0;
        if (stable && (!m_have || p != m_locked)) begin
            m_locked = p;
            m_have   = 1;
            m.dp     = p[7];
            m.bl     = p[6:0] == 7'h00;
            m.cnt    = (m.cnt == 8'd255) ? 8'd255 : m.cnt + 8'd1;
            found    = 0;
            v        = 0;
            for (int i = 0; i < 16; i++) if (glyph[i] == p[6:0]) begin found = 1; v = i; end
            if (found) begin
                m.digit = 4'(v);
                m.vld   = 1;
            end else if (!m.bl) begin
                m.err    = 1;
                m.sticky = 1;
            end
        end
        exp_q.push_back(m);
    endtask

    task automatic drive(input logic [7:0] p);
        seg_in = p;
        model_edge(p);
    endtask

    task automatic step(input logic [7:0] p, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_2);
            drive(p);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_digit",  32'(digit_out), 0);
        chk("rst_dp",     32'(dp_out), 0);
        chk("rst_blank",  32'(blank), 1);
        chk("rst_valid",  32'(digit_valid), 0);
        chk("rst_error",  32'(seg_error), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_count",  32'(change_count), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_2);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("digit_out",    32'(digit_out), 32'(e.digit));
                chk("dp_out",       32'(dp_out), 32'(e.dp));
                chk("blank",        32'(blank), 32'(e.bl));
                chk("digit_valid",  32'(digit_valid), 32'(e.vld));
                chk("seg_error",    32'(seg_error), 32'(e.err));
                chk("err_sticky",   32'(err_sticky), 32'(e.sticky));
                chk("change_count", 32'(change_count), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] p;
        model_reset();
        #1 reset_n = 1'b0;
        #2 chk_reset_outputs();
        @(negedge clk_2);
        reset_n = 1'b1;
        drive(8'h3F);
        step(8'h3F, 3);
        step(8'h4F, 6);
        step(8'h4F, 20);
        step(8'h06, 6);
        step(8'h5B, 2);
        step(8'h06, 6);
        step(8'h49, 4);
        step(8'hED, 5);
        step(8'h00, 5);
        for (int i = 0; i < 300; i++) step(i[0] ? 8'h5B : 8'h06, 4);
        @(posedge clk_2);
        #2 chk("count_saturated", 32'(change_count), 255);
        step(8'h66, 2);
        @(posedge clk_2);
        #3 reset_n = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk_2);
        seg_in = 8'h66;
        @(negedge clk_2);
        reset_n = 1'b1;
        drive(8'h66);
        step(8'h66, 4);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: p = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
                6:                p = {1'($urandom_range(0, 1)), 7'h00};
                default:          p = 8'($urandom_range(0, 255));
            endcase
            step(p, $urandom_range(1, 6));
        end
        repeat (3) @(posedge clk_2);
        #2 chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Receive-side counterpart of the 7-segment digit encoder: samples an 8-bit active-high segment bus (bit7 = dp, bits[6:0] = g..a) and recovers the hex digit it shows.
- Filters the bus so that only patterns held stable for STABLE_CYCLES clocks are accepted.
- Flags undecodable patterns and counts accepted digit changes.
- Sits beside the ALU/display path as a self-check monitor; its outputs go to LED/LCD debug fields.

Parameters:
- NBITS_SEG, 8, segment bus width (fixed: 7 segments + dp).
- STABLE_CYCLES, 4, consecutive identical samples required for acceptance (legal range 1..255).
- CNT_W, 8, width of change_count.

Ports:
- clk_2  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- seg_in  in  NBITS_SEG  segment pattern under observation.
- digit_out  out  4  last accepted valid digit value (0..15).
- dp_out  out  1  dp bit of the last accepted pattern.
- blank  out  1  last accepted pattern had bits[6:0] = 0.
- digit_valid  out  1  one-cycle pulse: valid digit accepted.
- seg_error  out  1  one-cycle pulse: non-blank, undecodable pattern accepted.
- err_sticky  out  1  set on any seg_error; cleared only by reset.
- change_count  out  CNT_W  number of acceptances, saturating at all-ones.

Behaviour:
- Clock is the single clk_2 domain. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - digit_out=0, dp_out=0, blank=1.
  - digit_valid=0, seg_error=0, err_sticky=0, change_count=0.
  - state=IDLE, samp=0, stab_cnt=0, have_lock=0.
- Sampling: samp <= seg_in on every edge.
- stab_cnt:
  - Becomes 1 when seg_in != samp.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - On the first edge after reset, stab_cnt becomes 1.
- Acceptance condition at an edge: the next stab_cnt equals STABLE_CYCLES, and (have_lock=0 or seg_in != locked).
- Acceptance latency: pattern P applied before edge 0 and held is accepted at edge STABLE_CYCLES-1. The pulse is high between that edge and the next one.
- On acceptance:
  - locked <= seg_in; have_lock <= 1.
  - dp_out <= seg_in[7]; blank <= (seg_in[6:0]==0); change_count++ (saturating).
  - Decodable pattern: digit_out <= value, digit_valid=1.
  - Non-blank and undecodable: seg_error=1, err_sticky=1, digit_out holds.
  - Blank: neither pulse, digit_out holds.
- Decode table, bits[6:0] (dp ignored):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- FSM states:
  - IDLE: no lock yet. Goes to SETTLING on the first sample.
  - SETTLING: counting. Goes to LOCKED on acceptance. If the pattern returns to locked before acceptance, goes back to LOCKED without a pulse.
  - LOCKED: goes to SETTLING when seg_in != locked.
- Glitches: any excursion shorter than STABLE_CYCLES is ignored. Re-holding the currently locked pattern never re-accepts.
- STABLE_CYCLES=1: accept at the first edge a new pattern is seen.
- Pulses are never asserted in consecutive cycles for the same pattern. A different pattern needs at least STABLE_CYCLES edges.
- Reset mid-settling: all state cleared immediately; the next pattern is treated as the first after reset.

Decomposition:
- Package seg7_pkg:
  - 16-entry pattern constant array SEG7_PATTERNS.
  - BLANK pattern constant.
  - state_t enum {IDLE, SETTLING, LOCKED}.
- Sub-module seg7_lut (combinational): input pattern[6:0] -> {hit, value[3:0]}; reused by future display checkers.
- Top-level seg7_decoder: sampling register, stability counter, FSM, output registers.

Test Plan:
- Reset release with seg_in=3F held 4 cycles -> digit_valid pulse at edge 3, digit_out=0, blank=0, change_count=1.
- 3F -> 4F (held 6 cycles) -> digit_valid once, digit_out=3, change_count=2. Then 4F held 20 more cycles -> no further pulses.
- Locked 06, glitch 5B for 2 cycles, back to 06 -> no pulse, digit_out=1, change_count unchanged.
- Apply 0x49 held 4 cycles -> seg_error pulse, err_sticky=1, digit_out unchanged. Then 0xED held -> digit_valid, digit_out=5, dp_out=1, err_sticky stays 1.
- Apply 0x00 held -> no pulses, blank=1, change_count++. Alternate 06/5B every 4 cycles for 300 changes -> change_count saturates at 255.
- Assert reset_n low during SETTLING at cycle 2 -> all outputs reset asynchronously. After release, the same pattern needs a full 4 cycles.
